// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared LEGv8 pipeline types: control bundle, ALUOp codes, XZR index
package cpu_pkg;

    localparam int XZR = 31;

    localparam logic [2:0] ALUOP_PASS = 3'b000;
    localparam logic [2:0] ALUOP_ADD  = 3'b010;
    localparam logic [2:0] ALUOP_SUB  = 3'b011;

    // Decoded control bundle, MSB first. The trailing rsvd bit pads the
    // bundle to 16 bits; decode drives it to 0.
    typedef struct packed {
        logic       set_flag;
        logic       reg2loc;
        logic       uncondbranch;
        logic       brtaken;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic       brtoreg;
        logic       brlink;
        logic [1:0] alusrc;
        logic [2:0] aluop;
        logic       rsvd;
    } ctrl_t;

endpackage

// File: rtl/flag_reg.sv
// rtl/flag_reg.sv - NZVC flag register with optional same-cycle bypass
//
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   upd           : commit alu_nzvc into the register on this edge
//   byp           : EX holds a live flag setter (used only with FLAG_FWD_EN)
//   alu_nzvc[3:0] : ALU flags of the instruction in EX {N,Z,V,C}
//   nzvc[3:0]     : flags presented to the control unit
// Macro FLAG_FWD_EN: when defined, nzvc bypasses alu_nzvc while byp is high.
module flag_reg
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       upd,
    input  logic       byp,
    input  logic [3:0] alu_nzvc,
    output logic [3:0] nzvc
);

    logic [3:0] flags_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else if (upd) begin
            flags_q <= alu_nzvc;
        end
    end

`ifdef FLAG_FWD_EN
    assign nzvc = byp ? alu_nzvc : flags_q;
`else
    logic unused_byp;
    assign unused_byp = byp;
    assign nzvc       = flags_q;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - LEGv8 ID/EX pipeline register with load-use/flag hazard stall and flush
//
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   id_valid, id_ctrl         : decode slot and its control bundle
//   id_rn/rm/rd, *_used       : register indices and which sources are read
//   id_cond_br                : decode holds B.cond
//   id_rdata1/2, id_imm, id_pc: operands, extended immediate, PC
//   flush                     : taken-branch redirect, squashes ID and EX
//   ex_alu_neg/zero/over/carry: ALU flags of the instruction in EX
//   ex_*                      : registered EX slot
//   stall                     : hold PC and IF/ID
//   negflag..carryflag        : flags to the control unit
// Macro FLAG_FWD_EN: bypass EX flags to the control unit instead of stalling B.cond.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 5,
    parameter int ZERO_REG = XZR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  ctrl_t             id_ctrl,
    input  logic [REG_W-1:0]  id_rn,
    input  logic [REG_W-1:0]  id_rm,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_rn_used,
    input  logic              id_rm_used,
    input  logic              id_cond_br,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic              flush,
    input  logic              ex_alu_neg,
    input  logic              ex_alu_zero,
    input  logic              ex_alu_over,
    input  logic              ex_alu_carry,
    output logic              ex_valid,
    output ctrl_t             ex_ctrl,
    output logic [REG_W-1:0]  ex_rn,
    output logic [REG_W-1:0]  ex_rm,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic              stall,
    output logic              negflag,
    output logic              zeroflag,
    output logic              overflag,
    output logic              carryflag
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    logic       hz_ld;
    logic       hz_flag;
    logic       ex_setter;
    logic [3:0] nzvc;

    assign ex_setter = ex_valid & ex_ctrl.set_flag;

    assign hz_ld = id_valid & ex_valid & ex_ctrl.memread & (ex_rd != ZR) &
                   ((id_rn_used & (id_rn == ex_rd)) | (id_rm_used & (id_rm == ex_rd)));

`ifdef FLAG_FWD_EN
    logic unused_cond_br;
    assign unused_cond_br = id_cond_br;
    assign hz_flag        = 1'b0;
`else
    // Flags from the EX setter are not architecturally visible until the
    // next edge, so a B.cond right behind it waits one cycle.
    assign hz_flag = id_valid & id_cond_br & ex_setter;
`endif

    assign stall = (hz_ld | hz_flag) & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_rn     <= '0;
            ex_rm     <= '0;
            ex_rd     <= '0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_imm    <= '0;
            ex_pc     <= '0;
        end else if (flush || stall) begin
            // Bubble: only valid/ctrl are cleared, data fields hold.
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid  <= id_valid;
            ex_ctrl   <= id_valid ? id_ctrl : '0;
            ex_rn     <= id_rn;
            ex_rm     <= id_rm;
            ex_rd     <= id_rd;
            ex_rdata1 <= id_rdata1;
            ex_rdata2 <= id_rdata2;
            ex_imm    <= id_imm;
            ex_pc     <= id_pc;
        end
    end

    flag_reg u_flag_reg (
        .clk      (clk),
        .reset    (reset),
        .upd      (ex_setter & ~flush),
        .byp      (ex_setter),
        .alu_nzvc ({ex_alu_neg, ex_alu_zero, ex_alu_over, ex_alu_carry}),
        .nzvc     (nzvc)
    );

    assign {negflag, zeroflag, overflag, carryflag} = nzvc;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the pipelined LEGv8 core. Sits directly downstream of the decode control unit.
- Registers the decoded control bundle, operands, register indices, immediate and PC into EX.
- Detects load-use hazards and inserts bubbles. Applies branch flushes.
- Owns the architectural NZVC flag register that feeds the control unit's conditional-branch decision.

Parameters:
- DATA_W, 64, operand/immediate/PC width
- REG_W, 5, register index width
- ZERO_REG, 31, XZR index; never causes a hazard

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_ctrl  in  ctrl_t(16)  SetFlag, Reg2Loc, Uncondbranch, BrTaken, MemRead, MemtoReg, MemWrite, RegWrite, BrtoReg, BrLink, ALUSrc[1:0], ALUOp[2:0]
- id_rn, id_rm, id_rd  in  REG_W  source 1, source 2 (already Reg2Loc-muxed), destination
- id_rn_used, id_rm_used  in  1  the source is actually read
- id_cond_br  in  1  decode holds B.cond
- id_rdata1, id_rdata2, id_imm, id_pc  in  DATA_W  operands, extended immediate, PC
- flush  in  1  taken-branch redirect from a later stage; squashes ID and EX
- ex_alu_neg, ex_alu_zero, ex_alu_over, ex_alu_carry  in  1  ALU flags for the instruction currently in EX
- ex_valid  out  1
- ex_ctrl  out  ctrl_t(16)
- ex_rn, ex_rm, ex_rd  out  REG_W
- ex_rdata1, ex_rdata2, ex_imm, ex_pc  out  DATA_W
- stall  out  1  hold PC and IF/ID this cycle
- negflag, zeroflag, overflag, carryflag  out  1  flags to the control unit

Behaviour:
- Reset (asynchronous, reset=0):
  - All ex_* = 0, ex_valid = 0.
  - Flag register = 0.
  - stall = 0, because stall depends on ex_valid.
  - Reset mid-operation discards EX contents immediately.
- Hazard (combinational):
  - hz_ld = id_valid & ex_valid & ex_ctrl.MemRead & (ex_rd != ZERO_REG) & ((id_rn_used & id_rn==ex_rd) | (id_rm_used & id_rm==ex_rd))
  - stall = (hz_ld | hz_flag) & ~flush
- Register update, per rising edge, in priority order:
  1. flush: ex_valid <= 0, ex_ctrl <= 0. Other fields don't-care; hold them.
  2. stall: bubble, same as flush. ID holds externally.
  3. Otherwise: capture all id_* fields; ex_valid <= id_valid; ex_ctrl <= id_valid ? id_ctrl : 0.
- Latency:
  - Data: 1 cycle ID to EX.
  - A load-use stall lasts exactly 1 cycle. The bubble clears ex_valid, so hz_ld drops the next cycle.
- Flag register: NZVC <= ex_alu_* on an edge where ex_valid & ex_ctrl.SetFlag & ~flush. Otherwise it holds. A squashed flag-setter never commits.
- Simultaneous events:
  - flush plus hazard: flush wins, and stall is 0.
  - A stall with ex_valid=0 is impossible.
  - A back-to-back load/consumer sequence gives one stall and then normal capture.
- Invariant: ex_ctrl == 0 whenever ex_valid == 0.

Optional Feature:
- Macro: FLAG_FWD_EN
- Defined:
  - Flag outputs = (ex_valid & ex_ctrl.SetFlag) ? ex_alu_* : flag register. This is a same-cycle bypass.
  - hz_flag = 0.
- Undefined:
  - Flag outputs come from the flag register only.
  - hz_flag = id_valid & id_cond_br & ex_valid & ex_ctrl.SetFlag. This gives a 1-cycle stall on a B.cond that follows a flag setter.

Decomposition:
- Package cpu_pkg holds:
  - ctrl_t packed struct (16 bits, field order as listed under id_ctrl)
  - ALUOp localparams: ADD=3'b010, SUB=3'b011, PASS=3'b000
  - XZR = 31
- One sub-module, flag_reg: NZVC storage plus the FLAG_FWD_EN bypass mux.

Test Plan:
1. Reset low while EX holds a valid ADDI (ex_ctrl.RegWrite=1) -> ex_valid=0, ex_ctrl=0, flags=0 immediately, without waiting for a clock edge.
2. EX=LDUR (MemRead=1, rd=3); ID=ADDS with rn=3, rn_used=1 -> stall=1 for one cycle. Next cycle: ex_valid=0, ex_ctrl=0. Cycle after: ADDS is in EX and stall=0.
3. EX=LDUR rd=31; ID rn=31 used -> stall=0, ID captured normally. Also: rm=3 with rm_used=0 -> stall=0.
4. Case 2 with flush=1 -> stall=0, next ex_valid=0. Also: EX=SUBS with ex_alu_neg=1 and flush=1 -> flags stay 0000.
5. EX=SUBS with ex_alu_neg=1, over=0:
   - After the edge, negflag=1.
   - FLAG_FWD_EN defined: negflag=1 in the same cycle.
   - Undefined: ID B.cond gives stall=1 for exactly one cycle.
6. Stream of 4 ADDI with id_valid=1 and no hazards -> each appears in EX one cycle later, ex_pc increments by 4, and stall never asserts.
